// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC owner, one-entry fetch register to decode; word at pc registered one edge later.
// Decode stall holds pc and the fetch register; branch flushes (1 bubble). Option: FETCH_BOUND_CHECK_EN.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rd,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus8,
   output logic        fetch_fault
);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_HOLD = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic        accept;
   logic        halted;
   logic        bound_hit;

`ifdef FETCH_BOUND_CHECK_EN
   localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);
   logic fetch_fault_q, fetch_fault_d;

   assign halted      = (state_q == S_HALT);
   assign bound_hit   = (pc_q >= PC_LIMIT);
   assign fetch_fault = fetch_fault_q;
`else
   assign halted      = 1'b0;
   assign bound_hit   = 1'b0;
   assign fetch_fault = 1'b0;
`endif

   assign accept = !if_valid_q || id_ready;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
`ifdef FETCH_BOUND_CHECK_EN
      fetch_fault_d = fetch_fault_q;
`endif
      if (halted) begin
         // Halt is terminal until reset; redirects are ignored here.
         state_d = S_HALT;
      end else if (branch_taken) begin
         pc_d       = branch_target & ~32'd3;
         if_valid_d = 1'b0;
         state_d    = S_RUN;
      end else if (accept) begin
         if (bound_hit) begin
`ifdef FETCH_BOUND_CHECK_EN
            fetch_fault_d = 1'b1;
`endif
            if_valid_d = 1'b0;
            state_d    = S_HALT;
         end else begin
            if_instr_d = imem_rd;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            state_d    = S_RUN;
         end
      end else begin
         state_d = S_HOLD;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_RUN;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_instr_q <= 32'd0;
         if_pc_q    <= 32'd0;
`ifdef FETCH_BOUND_CHECK_EN
         fetch_fault_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
`ifdef FETCH_BOUND_CHECK_EN
         fetch_fault_q <= fetch_fault_d;
`endif
      end
   end

   assign imem_addr   = pc_q;
   assign if_valid    = if_valid_q;
   assign if_instr    = if_instr_q;
   assign if_pc       = if_pc_q;
   assign if_pc_plus8 = if_pc_q + 32'd8;

endmodule
